// File: rtl/offset_pkg.sv
// -----------------------------------------------------------------------------
// offset_pkg
//   Shared definitions for the offset key conditioner:
//   - bit indices of the four direction keys inside keyRaw/keyState/offsetFlag
//   - per-key FSM state encoding
//   - default timing constants (25 MHz clock, 1 kHz timebase)
//   - opp_key(): index of the key on the same axis (up<->down, left<->right)
// -----------------------------------------------------------------------------
package offset_pkg;

  localparam int NUM_KEYS  = 4;
  localparam int KEY_UP    = 3;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_RIGHT = 0;

  localparam int DEF_CLK_DIV          = 25000;
  localparam int DEF_DEB_TICKS        = 20;
  localparam int DEF_RPT_DELAY_TICKS  = 500;
  localparam int DEF_RPT_PERIOD_TICKS = 100;
  localparam bit DEF_KEY_ACTIVE_LOW   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_HELD_DELAY  = 2'd1,
    ST_HELD_REPEAT = 2'd2
  } key_state_e;

  // Axis partners differ only in bit 0 of their index (3<->2, 1<->0).
  function automatic int opp_key(input int idx);
    return idx ^ 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   One key: two-flop synchronizer, debounce counter, typematic repeat timer.
//   The FSM only advances on timebase ticks supplied by the parent.
//
//   Ports
//     clk             : system clock
//     reset           : asynchronous active-low reset
//     tick_i          : one-clk timebase strobe shared by all keys
//     key_raw_i       : raw button level, asynchronous to clk
//     key_state_o     : registered debounced state, 1 = pressed
//     key_state_nxt_o : debounced state as it will be after this clock edge
//     press_evt_o     : one-clk strobe on the tick that accepts a press
//     rpt_evt_o       : one-clk strobe on each auto-repeat tick
//     state_o         : current FSM state, for observation
// -----------------------------------------------------------------------------
module key_debounce
  import offset_pkg::*;
#(
  parameter int DEB_TICKS        = DEF_DEB_TICKS,
  parameter int RPT_DELAY_TICKS  = DEF_RPT_DELAY_TICKS,
  parameter int RPT_PERIOD_TICKS = DEF_RPT_PERIOD_TICKS,
  parameter bit KEY_ACTIVE_LOW   = DEF_KEY_ACTIVE_LOW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic       key_raw_i,
  output logic       key_state_o,
  output logic       key_state_nxt_o,
  output logic       press_evt_o,
  output logic       rpt_evt_o,
  output key_state_e state_o
);

  localparam int RPT_MAX = (RPT_DELAY_TICKS > RPT_PERIOD_TICKS) ? RPT_DELAY_TICKS
                                                                : RPT_PERIOD_TICKS;
  localparam int DEB_W   = $clog2(DEB_TICKS) + 1;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic             RELEASED_LVL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEB_TICKS);
  localparam logic [RPT_W-1:0] RPT_LAST     = RPT_W'(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_DELAY    = RPT_W'(RPT_DELAY_TICKS);
  localparam logic [RPT_W-1:0] RPT_PERIOD   = RPT_W'(RPT_PERIOD_TICKS);

  logic             sync1_q, sync2_q;
  logic             pressed;
  key_state_e       state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d, deb_inc;
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic             key_state_q, key_state_d;
  logic             press_evt, rpt_evt;

  // Synchronizer resets to the released level so no phantom press follows reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= RELEASED_LVL;
      sync2_q <= RELEASED_LVL;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalized level: 1 = pressed regardless of button polarity.
  assign pressed = sync2_q ^ RELEASED_LVL;

  // Saturating increments; counters never wrap.
  assign deb_inc = (deb_q >= DEB_LAST) ? DEB_LAST : deb_q + DEB_W'(1);
  assign rpt_inc = (rpt_q >= RPT_LAST) ? RPT_LAST : rpt_q + RPT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      deb_q       <= '0;
      rpt_q       <= '0;
      key_state_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      rpt_q       <= rpt_d;
      key_state_q <= key_state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    rpt_d       = rpt_q;
    key_state_d = key_state_q;
    press_evt   = 1'b0;
    rpt_evt     = 1'b0;

    if (tick_i) begin
      unique case (state_q)
        ST_IDLE: begin
          deb_d = pressed ? deb_inc : '0;
          if (pressed && (deb_inc == DEB_LAST)) begin
            state_d     = ST_HELD_DELAY;
            key_state_d = 1'b1;
            press_evt   = 1'b1;
            deb_d       = '0;
            rpt_d       = '0;
          end
        end

        ST_HELD_DELAY, ST_HELD_REPEAT: begin
          deb_d = pressed ? '0 : deb_inc;
          // An accepted release wins over a repeat falling on the same tick.
          if (!pressed && (deb_inc == DEB_LAST)) begin
            state_d     = ST_IDLE;
            key_state_d = 1'b0;
            deb_d       = '0;
            rpt_d       = '0;
          end else begin
            rpt_d = rpt_inc;
            if ((state_q == ST_HELD_DELAY) && (rpt_inc == RPT_DELAY)) begin
              state_d = ST_HELD_REPEAT;
              rpt_evt = 1'b1;
              rpt_d   = '0;
            end else if ((state_q == ST_HELD_REPEAT) && (rpt_inc == RPT_PERIOD)) begin
              rpt_evt = 1'b1;
              rpt_d   = '0;
            end
          end
        end

        default: begin
          state_d     = ST_IDLE;
          key_state_d = 1'b0;
          deb_d       = '0;
          rpt_d       = '0;
        end
      endcase
    end
  end

  assign key_state_o     = key_state_q;
  assign key_state_nxt_o = key_state_d;
  assign press_evt_o     = press_evt;
  assign rpt_evt_o       = rpt_evt;
  assign state_o         = state_q;

endmodule

// File: rtl/offset_key_conditioner.sv
// -----------------------------------------------------------------------------
// offset_key_conditioner
//   Turns four raw direction buttons into clean one-clk move pulses with
//   auto-repeat; a key whose axis partner is held produces no pulses.
//
//   Ports
//     clk        : system clock
//     reset      : asynchronous active-low reset
//     keyRaw     : raw buttons {up, down, left, right}, asynchronous
//     offsetFlag : registered move pulses {up, down, left, right}
//     keyState   : debounced pressed state, 1 = pressed
//     dbgState   : per-key FSM state, key i in bits [2*i+1:2*i]
// -----------------------------------------------------------------------------
module offset_key_conditioner
  import offset_pkg::*;
#(
  parameter int CLK_DIV          = DEF_CLK_DIV,
  parameter int DEB_TICKS        = DEF_DEB_TICKS,
  parameter int RPT_DELAY_TICKS  = DEF_RPT_DELAY_TICKS,
  parameter int RPT_PERIOD_TICKS = DEF_RPT_PERIOD_TICKS,
  parameter bit KEY_ACTIVE_LOW   = DEF_KEY_ACTIVE_LOW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   keyRaw,
  output logic [NUM_KEYS-1:0]   offsetFlag,
  output logic [NUM_KEYS-1:0]   keyState,
  output logic [2*NUM_KEYS-1:0] dbgState
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0]    presc_q, presc_d;
  logic                tick;
  logic [NUM_KEYS-1:0] key_state, key_state_nxt, press_evt, rpt_evt;
  logic [NUM_KEYS-1:0] flag_q, flag_d;
  key_state_e          key_fsm [NUM_KEYS];

  // Shared timebase: one tick every CLK_DIV clocks.
  assign tick    = (presc_q == DIV_W'(CLK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + DIV_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      flag_q  <= '0;
    end else begin
      presc_q <= presc_d;
      flag_q  <= flag_d;
    end
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEB_TICKS       (DEB_TICKS),
      .RPT_DELAY_TICKS (RPT_DELAY_TICKS),
      .RPT_PERIOD_TICKS(RPT_PERIOD_TICKS),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_key (
      .clk            (clk),
      .reset          (reset),
      .tick_i         (tick),
      .key_raw_i      (keyRaw[gi]),
      .key_state_o    (key_state[gi]),
      .key_state_nxt_o(key_state_nxt[gi]),
      .press_evt_o    (press_evt[gi]),
      .rpt_evt_o      (rpt_evt[gi]),
      .state_o        (key_fsm[gi])
    );

    // Gating uses the partner's post-tick state so that opposing keys
    // accepted on the same tick cancel each other.
    assign flag_d[gi] = (press_evt[gi] | rpt_evt[gi]) & ~key_state_nxt[opp_key(gi)];

    assign dbgState[2*gi +: 2] = key_fsm[gi];
  end

  assign offsetFlag = flag_q;
  assign keyState   = key_state;

endmodule
